led_receiver: RTL and testbench
===============================

LED_RECEIVER -- requirements
Module: led_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter THRESH_NS, default 600, the high-time boundary separating 0 bits from 1 bits.
REQ-003 SHALL have parameter HIGH_MAX_NS, default 2000, the longest legal high pulse.
REQ-004 SHALL have parameter RESET_NS, default 50_000, the minimum low time that counts as a latch/reset gap.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port din, input, 1 bit: WS2812B serial line, asynchronous to clk.
REQ-008 SHALL have port rgb_data, output, 24 bits: last complete pixel word, first-received bit in [23].
REQ-009 SHALL have port data_valid, output, 1 bit: one-cycle pulse when rgb_data is updated.
REQ-010 SHALL have port frame_end, output, 1 bit: one-cycle pulse on reset-gap detection.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on a protocol violation.
REQ-012 SHALL have port busy, output, 1 bit: high while in HIGH or LOW state.
REQ-013 SHALL have port fwd_out, output, 1 bit: cascade output for the downstream LED.

Function
REQ-014 Cycle constants SHALL be computed as CLK_FREQ*X_NS/1e9, truncated: THRESH_CYC, HIGH_MAX_CYC, RESET_CYC (16/54/1350 at defaults).
REQ-015 din SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized signal ds; edges are detected from ds versus its previous value.
REQ-016 The single timing counter SHALL be wide enough for RESET_CYC, SHALL saturate at RESET_CYC, and SHALL clear on every ds edge.
REQ-017 The FSM SHALL have states WAIT_GAP, IDLE, HIGH and LOW; it enters WAIT_GAP on reset.
REQ-018 WAIT_GAP: on ds low for RESET_CYC consecutive cycles -> IDLE; any ds high restarts the count; no frame_end pulse is issued on this exit.
REQ-019 IDLE: on a ds rising edge -> HIGH, with the counter cleared.
REQ-020 HIGH: on a ds falling edge, decide bit = (count >= THRESH_CYC), shift it in, then -> LOW.
REQ-021 HIGH: if count reaches HIGH_MAX_CYC before the falling edge -> pulse err, discard the partial word, clear the pass flag, -> WAIT_GAP.
REQ-022 LOW: on a ds rising edge -> HIGH.
REQ-023 LOW: if count reaches RESET_CYC -> pulse frame_end, clear the pass flag, -> IDLE.
REQ-024 LOW: if bit_cnt != 0 when the gap is detected -> also pulse err in the same cycle and discard the partial word.
REQ-025 bit_cnt SHALL count 0..23.
REQ-026 On the 24th decided bit of a frame while the pass flag is clear: load rgb_data, pulse data_valid in the following cycle, reset bit_cnt to 0, and set the pass flag.
REQ-027 While the pass flag is set, no bits SHALL be captured and rgb_data, data_valid and bit_cnt SHALL be unaffected.
REQ-028 fwd_out SHALL be the registered value of (ds AND pass flag).
REQ-029 The pass flag SHALL be set by the same clock edge that loads rgb_data, so forwarding begins with the first high of the 25th bit.
REQ-030 rgb_data SHALL hold its value until the next complete pixel; it is never cleared by frame_end or err.
REQ-031 If a ds edge and a counter threshold land in the same cycle, the edge SHALL take priority.

Reset
REQ-032 rst low SHALL asynchronously force: rgb_data=0, data_valid=0, frame_end=0, err=0, busy=0, fwd_out=0, pass flag=0, bit_cnt=0, synchronizer flops=0, state=WAIT_GAP.
REQ-033 rst asserted mid-frame SHALL discard the partial word, and no pulse SHALL be produced on release.
REQ-034 After rst is released, the block SHALL require a full RESET_CYC low period before decoding.

Verification
REQ-035 Bench: 1350-cycle low, then 24 bits encoding 0xA5C30F (1 = 22 high/12 low cycles, 0 = 11 high/23 low), then 1400-cycle low -> exactly one data_valid with rgb_data=0xA5C30F, then exactly one frame_end, err never asserted.
REQ-036 Bench: one frame of 48 bits, 0x00FF00 then 0x123456 -> rgb_data=0x00FF00, and fwd_out reproduces the 0x123456 waveform delayed by 3 cycles, then stays 0 after frame_end.
REQ-037 Bench: high pulse held 60 cycles at bit 5 -> err pulses once at cycle 54 of the high, no data_valid, and a following clean frame still decodes.
REQ-038 Bench: 10 bits, then a 1400-cycle low -> frame_end and err in the same cycle, rgb_data unchanged.
REQ-039 Bench: high times of 15 and 16 cycles -> decoded as 0 and 1 respectively (threshold boundary).
REQ-040 Bench: rst pulsed low during bit 12 -> all outputs 0 immediately, and a decode starting less than 1350 cycles after release is ignored.

Source files
------------

// File: rtl/led_receiver.sv
// WS2812B receiver: decodes the first 24-bit pixel of each frame and forwards the rest of the frame.
// Outputs are registered; data_valid follows the 24th bit's falling edge on the synchronized line by one cycle.
module led_receiver #(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int THRESH_NS   = 600,
  parameter int HIGH_MAX_NS = 2000,
  parameter int RESET_NS    = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic        data_valid,
  output logic        frame_end,
  output logic        err,
  output logic        busy,
  output logic        fwd_out
);

  localparam int THRESH_CYC   = int'((64'(CLK_FREQ) * 64'(THRESH_NS))   / 64'd1_000_000_000);
  localparam int HIGH_MAX_CYC = int'((64'(CLK_FREQ) * 64'(HIGH_MAX_NS)) / 64'd1_000_000_000);
  localparam int RESET_CYC    = int'((64'(CLK_FREQ) * 64'(RESET_NS))    / 64'd1_000_000_000);
  localparam int CW           = $clog2(RESET_CYC + 1);

  localparam logic [CW:0]   THRESH_L = THRESH_CYC[CW:0];
  localparam logic [CW:0]   HMAX_L   = HIGH_MAX_CYC[CW:0];
  localparam logic [CW:0]   RESET_L  = RESET_CYC[CW:0];
  localparam logic [CW-1:0] RESET_C  = RESET_CYC[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

  state_t        state_q;
  logic          sync1_q, ds_q, ds_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   level_cyc;
  logic          rise, fall, bit_val, gap_hit;
  logic [22:0]   shift_q;
  logic [4:0]    bit_cnt_q;
  logic          pass_q;
  logic [23:0]   rgb_q;
  logic          dv_q, fe_q, err_q, busy_q, fwd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      ds_q      <= 1'b0;
      ds_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= din;
      ds_q      <= sync1_q;
      ds_prev_q <= ds_q;
      cnt_q     <= cnt_d;
    end
  end

  // level_cyc is the number of completed cycles the current ds level has been held.
  always_comb begin
    rise      = ds_q & ~ds_prev_q;
    fall      = ~ds_q & ds_prev_q;
    level_cyc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    bit_val   = (level_cyc >= THRESH_L);
    gap_hit   = ~ds_q && (level_cyc >= RESET_L);
    cnt_d     = cnt_q;
    if (rise || fall)
      cnt_d = '0;
    else if (cnt_q != RESET_C)
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT_GAP;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pass_q    <= 1'b0;
      rgb_q     <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      fwd_q     <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      fe_q  <= 1'b0;
      err_q <= 1'b0;
      fwd_q <= ds_q & pass_q;
      case (state_q)
        WAIT_GAP: begin
          if (gap_hit) state_q <= IDLE;
        end
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_q <= LOW;
            if (!pass_q) begin
              if (bit_cnt_q == 5'd23) begin
                rgb_q     <= {shift_q, bit_val};
                dv_q      <= 1'b1;
                bit_cnt_q <= '0;
                pass_q    <= 1'b1;
              end else begin
                shift_q   <= {shift_q[21:0], bit_val};
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end else if (level_cyc >= HMAX_L) begin
            err_q     <= 1'b1;
            bit_cnt_q <= '0;
            pass_q    <= 1'b0;
            state_q   <= WAIT_GAP;
            busy_q    <= 1'b0;
          end
        end
        LOW: begin
          if (rise) begin
            state_q <= HIGH;
          end else if (gap_hit) begin
            fe_q      <= 1'b1;
            err_q     <= (bit_cnt_q != 5'd0);
            bit_cnt_q <= '0;
            pass_q    <= 1'b0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_GAP;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rgb_data   = rgb_q;
  assign data_valid = dv_q;
  assign frame_end  = fe_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign fwd_out    = fwd_q;

endmodule

// File: tb/tb_led_receiver.sv
// Drives WS2812B frames with randomized pulse widths; expected pixels come from decoding the
// generated pulse widths against the nanosecond threshold.
module tb_led_receiver;

  localparam int TH = int'(64'd27_000_000 * 64'd600 / 64'd1_000_000_000);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic [23:0] rgb_data;
  logic        data_valid, frame_end, err, busy, fwd_out;

  led_receiver dut (
    .clk(clk), .rst(rst), .din(din), .rgb_data(rgb_data), .data_valid(data_valid),
    .frame_end(frame_end), .err(err), .busy(busy), .fwd_out(fwd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          din_at [0:65535];
  bit          fwd_at [0:65535];
  int          dv_n = 0, fe_n = 0, err_n = 0;
  int          dv_cyc = -1, fe_cyc = -1, err_cyc = -1;
  logic [23:0] last_dv = '0;

  always @(negedge clk) begin
    if (cyc < 65536) begin
      din_at[cyc] = din;
      fwd_at[cyc] = fwd_out;
    end
    if (data_valid) begin dv_n++; dv_cyc = cyc; last_dv = rgb_data; end
    if (frame_end) begin fe_n++; fe_cyc = cyc; end
    if (err) begin err_n++; err_cyc = cyc; end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_fixed(input logic [23:0] w, input int hi1, input int lo1,
                            input int hi0, input int lo0);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) begin drive(1'b1, hi1); drive(1'b0, lo1); end
      else      begin drive(1'b1, hi0); drive(1'b0, lo0); end
    end
  endtask

  task automatic send_rand(input int nbits, output logic [23:0] word, output int hi_sum);
    word   = '0;
    hi_sum = 0;
    for (int i = 0; i < nbits; i++) begin
      int hi, lo;
      hi = int'($urandom_range(3, 50));
      lo = int'($urandom_range(3, 40));
      word = {word[22:0], (hi >= TH)};
      hi_sum += hi;
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"},  {8'h0, rgb_data}, 32'h0);
    check({tag, "_dv"},   {31'h0, data_valid}, 32'h0);
    check({tag, "_fe"},   {31'h0, frame_end}, 32'h0);
    check({tag, "_err"},  {31'h0, err}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_fwd"},  {31'h0, fwd_out}, 32'h0);
  endtask

  initial begin
    logic [23:0] w, w2, pat;
    int hs, dv0, fe0, err0, s, e, r, mism, fh, hi1, hi0, ones;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Nominal frame with fixed timing.
    drive(1'b0, 1350);
    send_fixed(24'hA5C30F, 22, 12, 11, 23);
    drive(1'b0, 1400);
    check("s1_dv_count", dv_n, 1);
    check("s1_rgb", {8'h0, last_dv}, 32'h00A5C30F);
    check("s1_fe_count", fe_n, 1);
    check("s1_err_count", err_n, 0);
    check("s1_fe_after_dv", {31'h0, fe_cyc > dv_cyc}, 32'h1);
    check("s1_busy_idle", {31'h0, busy}, 32'h0);

    // Threshold boundary: 15-cycle highs are 0, 16-cycle highs are 1.
    pat = 24'($urandom);
    dv0 = dv_n; err0 = err_n;
    send_fixed(pat, 16, 20, 15, 20);
    drive(1'b0, 1400);
    check("s2_dv_count", dv_n - dv0, 1);
    check("s2_rgb", {8'h0, last_dv}, {8'h0, pat});
    check("s2_err", err_n - err0, 0);

    // Random pulse widths across both sides of the threshold.
    for (int k = 0; k < 4; k++) begin
      dv0 = dv_n; fe0 = fe_n; err0 = err_n;
      send_rand(24, w, hs);
      drive(1'b0, 1400);
      check("s3_dv_count", dv_n - dv0, 1);
      check("s3_rgb", {8'h0, last_dv}, {8'h0, w});
      check("s3_fe_count", fe_n - fe0, 1);
      check("s3_err", err_n - err0, 0);
    end

    // 48-bit frame: first pixel captured, second forwarded 3 cycles late.
    dv0 = dv_n; fe0 = fe_n; err0 = err_n;
    send_fixed(24'h00FF00, 22, 12, 11, 23);
    hi1 = int'($urandom_range(16, 50));
    hi0 = int'($urandom_range(3, 15));
    w2  = 24'h123456;
    ones = $countones(w2);
    s = cyc;
    send_fixed(w2, hi1, int'($urandom_range(5, 30)), hi0, int'($urandom_range(5, 30)));
    drive(1'b0, 1400);
    e = cyc;
    mism = 0; fh = 0;
    for (int c = s; c < e; c++) begin
      bit ex;
      ex = (c - 3 >= s) ? din_at[c - 3] : 1'b0;
      if (fwd_at[c] != ex) mism++;
      if (fwd_at[c]) fh++;
    end
    check("s4_dv_count", dv_n - dv0, 1);
    check("s4_rgb", {8'h0, rgb_data}, 32'h0000FF00);
    check("s4_fwd_mismatch", mism, 0);
    check("s4_fwd_high_cycles", fh, ones * hi1 + (24 - ones) * hi0);
    check("s4_fe_count", fe_n - fe0, 1);
    check("s4_err", err_n - err0, 0);
    fh = 0;
    for (int c = fe_cyc; c < e; c++) if (fwd_at[c]) fh++;
    check("s4_fwd_after_fe", fh, 0);

    // Over-long high at bit 5 aborts the frame; a later frame still decodes.
    dv0 = dv_n; fe0 = fe_n; err0 = err_n;
    send_rand(5, w, hs);
    r = cyc;
    drive(1'b1, 60);
    drive(1'b0, 1400);
    check("s5_err_count", err_n - err0, 1);
    check("s5_err_window", {31'h0, (err_cyc - r >= 54) && (err_cyc - r <= 58)}, 32'h1);
    check("s5_no_dv", dv_n - dv0, 0);
    check("s5_no_fe", fe_n - fe0, 0);
    send_rand(24, w, hs);
    drive(1'b0, 1400);
    check("s5_recover_dv", dv_n - dv0, 1);
    check("s5_recover_rgb", {8'h0, last_dv}, {8'h0, w});
    check("s5_recover_fe", fe_n - fe0, 1);

    // Short frame: gap with partial word gives frame_end and err together.
    pat = rgb_data;
    dv0 = dv_n; fe0 = fe_n; err0 = err_n;
    send_rand(10, w, hs);
    drive(1'b0, 1400);
    check("s6_fe_count", fe_n - fe0, 1);
    check("s6_err_count", err_n - err0, 1);
    check("s6_same_cycle", fe_cyc, err_cyc);
    check("s6_no_dv", dv_n - dv0, 0);
    check("s6_rgb_held", {8'h0, rgb_data}, {8'h0, pat});

    // Reset mid-frame, then an early decode that must be ignored.
    send_rand(12, w, hs);
    drive(1'b1, 5);
    check("s7_busy_mid", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    check_reset_outputs("s7_async");
    din = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    dv0 = dv_n; fe0 = fe_n; err0 = err_n;
    drive(1'b0, 600);
    send_rand(24, w, hs);
    drive(1'b0, 1400);
    check("s7_early_dv", dv_n - dv0, 0);
    check("s7_early_fe", fe_n - fe0, 0);
    check("s7_early_err", err_n - err0, 0);
    check("s7_rgb_zero", {8'h0, rgb_data}, 32'h0);
    send_rand(24, w, hs);
    drive(1'b0, 1400);
    check("s7_late_dv", dv_n - dv0, 1);
    check("s7_late_rgb", {8'h0, last_dv}, {8'h0, w});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
